booth_r4_mul: RTL and testbench
===============================

BOOTH_R4_MUL -- requirements
Module: booth_r4_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to multiply; it is sampled only in IDLE.
REQ-005 The block SHALL have port signed_mode, input, 1: 1 means two's-complement operands, 0 means unsigned; it is sampled with start.
REQ-006 The block SHALL have port multiplicand_in, input, WIDTH, operand A, sampled with start.
REQ-007 The block SHALL have port multiplicator_in, input, WIDTH, operand B, sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a single-cycle pulse indicating that the product is valid.
REQ-010 The block SHALL have port multiplication, output, 2*WIDTH, the registered product, held until the next completion.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
- IDLE -> RUN on a rising edge with start=1.
- RUN -> DONE after the last iteration.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 On acceptance, the block SHALL capture both operands and signed_mode, and extend each operand to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise.
REQ-013 RUN SHALL perform exactly (WIDTH+2)/2 radix-4 Booth iterations, one per cycle.
- Each iteration recodes a 3-bit multiplier window into one of {0, +A, -A, +2A, -2A}.
- It adds the selected value into the accumulator's upper half.
- It then arithmetic-shifts the accumulator right by 2.
REQ-014 The result SHALL be the low 2*WIDTH bits of the exact product, interpreted as signed or unsigned according to the captured mode.
REQ-015 Latency SHALL be fixed: done and the updated multiplication become visible exactly (WIDTH+2)/2+1 rising edges after the accepting edge (10 edges for WIDTH=16).
REQ-016 busy SHALL be 1 in RUN and DONE and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-017 start asserted while busy=1 SHALL be ignored, with no queuing and no corruption of the operation in flight.
REQ-018 start held high continuously SHALL cause a new acceptance on the first IDLE cycle after DONE, giving back-to-back operations with one idle cycle between them.
REQ-019 Changes on the operand and mode inputs after acceptance SHALL NOT affect the result in progress.
REQ-020 multiplication SHALL change only on entry to DONE and hold its value otherwise.

Reset
REQ-021 While rst=0, the block SHALL force state=IDLE, busy=0, done=0, multiplication=0, and clear the accumulator and iteration counter.
REQ-022 Reset asserted mid-RUN SHALL abort the operation immediately; no done pulse SHALL follow its release.
REQ-023 start SHALL be honoured on the first rising edge after rst deasserts.

Structure
REQ-024 Package booth_pkg SHALL hold the FSM state type and the Booth recode select type {ZERO, POS1, NEG1, POS2, NEG2}.
REQ-025 Sub-module booth_r4_enc SHALL be purely combinational: a 3-bit window in, a select code out.
REQ-026 The iteration counter SHALL be sized $clog2((WIDTH+2)/2)+1 bits.

Verification (WIDTH=16)
REQ-027 Signed: 0xD4C9 x 0xD4C9 (-11063^2) -> multiplication=0x074B85D1, with done exactly 10 edges after acceptance.
REQ-028 Signed: 0xD4C9 x 0x6572 -> 0xEEE00E82 (-287306110); unsigned: 0xFFFF x 0xFFFF -> 0xFFFE0001.
REQ-029 Corner cases SHALL be covered:
- signed 0xFFFF x 0xFFFF -> 0x00000001;
- signed 0x8000 x 0x8000 -> 0x40000000;
- either operand 0 -> 0.
REQ-030 start pulsed during RUN with different operands -> ignored; the first result is correct and a single done pulse occurs.
REQ-031 rst=0 at cycle 4 of RUN -> outputs are 0 immediately, and no done pulse follows release; a new start then yields a correct result.
REQ-032 The bench SHALL run 1000 random operands and modes, checking each result against a reference model, plus a start-held-high back-to-back run with the 1-cycle IDLE gap checked.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: controller states and
// the partial-product select code produced by the window recoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    NEG1,
    POS2,
    NEG2
  } booth_sel_e;

endpackage : booth_pkg

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b(i+1), b(i), b(i-1)}
// onto the partial-product multiple to add, one of {0, +A, -A, +2A, -2A}.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] win_i,
  output booth_sel_e sel_o
);

  // Pure lookup of the standard radix-4 recoding table.
  always_comb begin
    sel_o = ZERO;
    unique case (win_i)
      3'b000:  sel_o = ZERO;
      3'b001:  sel_o = POS1;
      3'b010:  sel_o = POS1;
      3'b011:  sel_o = POS2;
      3'b100:  sel_o = NEG2;
      3'b101:  sel_o = NEG1;
      3'b110:  sel_o = NEG1;
      3'b111:  sel_o = ZERO;
      default: sel_o = ZERO;
    endcase
  end

endmodule : booth_r4_enc

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Operands are extended to WIDTH+2 bits so one datapath serves both modes;
// RUN retires two multiplier bits per cycle, then one extra RUN cycle
// registers the product so done lands (WIDTH+2)/2+1 edges after acceptance.
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplicator_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   multiplication
);

  // EW: extended operand width; HW: upper accumulator half, with headroom
  // for +/-2A; AW: full accumulator {upper, multiplier, appended zero bit}.
  localparam int EW   = WIDTH + 2;
  localparam int ITER = EW / 2;
  localparam int HW   = EW + 2;
  localparam int AW   = HW + EW + 1;
  localparam int CW   = $clog2(ITER) + 1;

  booth_state_e             state_q;
  logic                     busy_q;
  logic                     done_q;
  logic [2*WIDTH-1:0]       mult_q;
  logic [CW-1:0]            cnt_q;
  logic signed [AW-1:0]     acc_q;
  logic signed [HW-1:0]     mcand_q;

  booth_sel_e               sel;
  logic signed [HW-1:0]     addend_d;
  logic signed [HW-1:0]     hi_sum_d;
  logic signed [AW-1:0]     acc_sum_d;
  logic signed [AW-1:0]     acc_d;

  // Multiplicand extended into the upper-half width.
  function automatic logic signed [HW-1:0] ext_hw(input logic [WIDTH-1:0] v,
                                                  input logic sm);
    return sm ? {{(HW-WIDTH){v[WIDTH-1]}}, v} : {{(HW-WIDTH){1'b0}}, v};
  endfunction

  // Multiplier extended by two bits so the last window sees the true sign.
  function automatic logic [EW-1:0] ext_ew(input logic [WIDTH-1:0] v,
                                           input logic sm);
    return sm ? {{(EW-WIDTH){v[WIDTH-1]}}, v} : {{(EW-WIDTH){1'b0}}, v};
  endfunction

  booth_r4_enc u_enc (
    .win_i (acc_q[2:0]),
    .sel_o (sel)
  );

  // One Booth step: add the selected multiple into the upper half, then
  // arithmetic-shift the whole accumulator right by two.
  always_comb begin
    addend_d = '0;
    unique case (sel)
      POS1:    addend_d = mcand_q;
      NEG1:    addend_d = -mcand_q;
      POS2:    addend_d = mcand_q <<< 1;
      NEG2:    addend_d = -(mcand_q <<< 1);
      default: addend_d = '0;
    endcase
    hi_sum_d  = $signed(acc_q[AW-1 -: HW]) + addend_d;
    acc_sum_d = {hi_sum_d, acc_q[AW-HW-1:0]};
    acc_d     = acc_sum_d >>> 2;
  end

  // Controller FSM with registered busy/done/product and the datapath state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mult_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= ext_hw(multiplicand_in, signed_mode);
            acc_q   <= {{HW{1'b0}}, ext_ew(multiplicator_in, signed_mode), 1'b0};
          end
        end
        RUN: begin
          if (cnt_q == CW'(ITER)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            mult_q  <= acc_q[2*WIDTH:1];
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign multiplication = mult_q;

endmodule : booth_r4_mul

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul (WIDTH=16): directed vector table, start-during-RUN,
// reset-abort, back-to-back and random operations with a scoreboard queue.
module tb_booth_r4_mul;

  localparam int W   = 16;
  localparam int LAT = (W + 2) / 2 + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic            smode;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  mult;

  int checks;
  int failures;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  booth_r4_mul #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .signed_mode      (smode),
    .multiplicand_in  (mcand),
    .multiplicator_in (mplier),
    .busy             (busy),
    .done             (done),
    .multiplication   (mult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product, computed in 64-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic sm);
    longint pa, pb, p;
    pa = sm ? longint'($signed(a)) : longint'({48'd0, a});
    pb = sm ? longint'($signed(b)) : longint'({48'd0, b});
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Launch one operation (called away from clock edges) and follow it for
  // a window of edges: latency, result, single done pulse, hold, busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input logic [2*W-1:0] exp,
                        input int pulse_at, input string nm);
    int dones;
    int lat;
    int win;
    logic ok_hold;
    logic ok_busy;
    logic [2*W-1:0] e;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    smode  = sm;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    smode  = 1'($urandom);
    chk({nm, " busy_after_accept"}, 64'(busy), 64'd1);
    dones   = 0;
    lat     = -1;
    ok_hold = 1'b1;
    ok_busy = 1'b1;
    win     = (pulse_at > 0) ? 26 : LAT + 3;
    for (int ed = 1; ed <= win; ed++) begin
      @(posedge clk); #1;
      if (ed == pulse_at) begin
        start  = 1'b1;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        smode  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (lat < 0) lat = ed;
        if (exp_q.size() == 0) begin
          chk({nm, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, " result"}, 64'(mult), 64'(e));
          last_exp = e;
        end
      end else if (mult !== last_exp) begin
        ok_hold = 1'b0;
      end
      if (lat < 0 && busy !== 1'b1) ok_busy = 1'b0;
      if (lat > 0 && ed == lat + 1 && busy !== 1'b0) ok_busy = 1'b0;
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(LAT));
    chk({nm, " done_pulses"}, 64'(dones), 64'd1);
    chk({nm, " hold"}, 64'(ok_hold), 64'd1);
    chk({nm, " busy_profile"}, 64'(ok_busy), 64'd1);
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    int idle;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;
    logic [2*W-1:0] bexp;

    checks   = 0;
    failures = 0;
    last_exp = '0;
    rst    = 1'b0;
    start  = 1'b0;
    smode  = 1'b0;
    mcand  = '0;
    mplier = '0;

    vecs.push_back('{16'hD4C9, 16'hD4C9, 1'b1, 32'h074B85D1});
    vecs.push_back('{16'hD4C9, 16'h6572, 1'b1, 32'hEEE00E82});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 32'h40000000});
    vecs.push_back('{16'h0000, 16'h1234, 1'b1, 32'h00000000});
    vecs.push_back('{16'h8000, 16'h0000, 1'b1, 32'h00000000});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 32'h00000000});
    vecs.push_back('{16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset mult", 64'(mult), 64'd0);
    rst = 1'b1;

    // Directed vectors; the first launches on the first edge after release.
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, -1, $sformatf("vec%0d", i));

    // start pulsed mid-RUN with other operands must be ignored.
    run_op(16'hD4C9, 16'h6572, 1'b1, 32'hEEE00E82, 3, "ign_start");

    // Reset in cycle 4 of RUN aborts at once; next start works immediately.
    start  = 1'b1;
    mcand  = 16'h1234;
    mplier = 16'h5678;
    smode  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort mult", 64'(mult), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    last_exp = '0;
    run_op(16'hD4C9, 16'hD4C9, 1'b1, 32'h074B85D1, -1, "after_abort");

    // start held high: back-to-back operations with one idle cycle.
    bexp   = model(16'h1357, 16'hF00D, 1'b1);
    start  = 1'b1;
    mcand  = 16'h1357;
    mplier = 16'hF00D;
    smode  = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    idle = 0;
    for (int ed = 1; ed <= 2 * LAT + 2; ed++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = ed;
        else if (d2 < 0) d2 = ed;
        chk("b2b result", 64'(mult), 64'(bexp));
      end
      if (!busy) idle++;
    end
    start = 1'b0;
    chk("b2b first_done", 64'(d1), 64'(LAT));
    chk("b2b second_done", 64'(d2), 64'(2 * LAT + 2));
    chk("b2b done_count", 64'(ndone), 64'd2);
    chk("b2b idle_cycles", 64'(idle), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b drained", 64'(busy), 64'd0);
    last_exp = bexp;

    // Random operands and modes against the reference model.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, model(ra, rb, rs), -1, $sformatf("rnd%0d", n));
    end

    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_booth_r4_mul
